// File: rtl/enemy_spawn_ctrl.sv
// enemy_spawn_ctrl: game-flow controller for the two enemy cars.
// Counts tick_in strobes to pace spawn attempts and speed-ups. Picks a lane
// from a 4-bit LFSR and hands each spawn to the addressed enemy over a
// valid/ready handshake. Ramps the descent divider and freezes on collision.
// Optional build macro LANE_NO_REPEAT_EN: consecutive accepted spawns never
// reuse the same lane.
module enemy_spawn_ctrl #(
  parameter int         LEFT_X         = 197,
  parameter int         CENTER_X       = 279,
  parameter int         RIGHT_X        = 361,
  parameter int         SPAWN_INTERVAL = 14,
  parameter int         SPEEDUP_EVERY  = 50,
  parameter int         PERIOD_INIT    = 100000,
  parameter int         PERIOD_STEP    = 1000,
  parameter int         PERIOD_MIN     = 20000,
  parameter logic [3:0] LFSR_SEED      = 4'b1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start,
  input  logic        collision,
  input  logic        spawn_ready,
  output logic        spawn_valid,
  output logic        spawn_slot,
  output logic [9:0]  spawn_x,
  output logic [24:0] step_period,
  output logic [5:0]  level,
  output logic [1:0]  game_state
);

  localparam int SC_W = $clog2(SPAWN_INTERVAL);
  localparam int PC_W = $clog2(SPEEDUP_EVERY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CRASHED = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      lfsr;
  logic [SC_W-1:0] spawn_cnt;
  logic [PC_W-1:0] speed_cnt;

  logic            spawn_wrap;
  logic            speed_wrap;
  logic            xfer;
  logic [1:0]      chosen_lane;

`ifdef LANE_NO_REPEAT_EN
  logic [1:0]      last_lane;
  logic [1:0]      cur_lane;
  logic [1:0]      ref_lane;
  logic [1:0]      raw_lane;
`endif

  // Fibonacci LFSR, x^4 + x^3 + 1; the zero state is unreachable from a nonzero seed.
  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    lfsr_next = {v[2:0], v[3] ^ v[2]};
  endfunction

  // Lane = value mod 3 (0 left, 1 centre, 2 right), tabulated for all 16 values.
  function automatic logic [1:0] lane_lut(input logic [3:0] v);
    case (v)
      4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: lane_lut = 2'd0;
      4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       lane_lut = 2'd1;
      default:                              lane_lut = 2'd2;
    endcase
  endfunction

  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_x = 10'(LEFT_X);
      2'd2:    lane_x = 10'(RIGHT_X);
      default: lane_x = 10'(CENTER_X);
    endcase
  endfunction

  // One speed-up: subtract in 26 signed bits so a small period cannot wrap, then floor.
  function automatic logic [24:0] period_dec(input logic [24:0] p);
    logic signed [25:0] diff;
    diff = $signed({1'b0, p}) - $signed(26'(PERIOD_STEP));
    if (diff < $signed(26'(PERIOD_MIN)))
      period_dec = 25'(PERIOD_MIN);
    else
      period_dec = diff[24:0];
  endfunction

  function automatic logic [5:0] level_inc(input logic [5:0] lv);
    level_inc = (lv == 6'd63) ? lv : lv + 6'd1;
  endfunction

  assign spawn_wrap = tick_in && (spawn_cnt == SC_W'(SPAWN_INTERVAL - 1));
  assign speed_wrap = tick_in && (speed_cnt == PC_W'(SPEEDUP_EVERY - 1));
  assign xfer       = spawn_valid && spawn_ready;
  assign game_state = state;

`ifdef LANE_NO_REPEAT_EN
  // Compare against the lane of the spawn being accepted this cycle, if any.
  assign raw_lane    = lane_lut(lfsr);
  assign ref_lane    = xfer ? cur_lane : last_lane;
  assign chosen_lane = (raw_lane != ref_lane) ? raw_lane :
                       (raw_lane == 2'd2)     ? 2'd0 : raw_lane + 2'd1;
`else
  assign chosen_lane = lane_lut(lfsr);
`endif

  // Game FSM with registered spawn handshake, pacing counters and speed ramp.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      spawn_valid <= 1'b0;
      spawn_slot  <= 1'b0;
      spawn_x     <= 10'(CENTER_X);
      step_period <= 25'(PERIOD_INIT);
      level       <= 6'd0;
      lfsr        <= LFSR_SEED;
      spawn_cnt   <= '0;
      speed_cnt   <= '0;
`ifdef LANE_NO_REPEAT_EN
      last_lane   <= 2'd1;
      cur_lane    <= 2'd1;
`endif
    end else begin
      if (tick_in)
        lfsr <= lfsr_next(lfsr);

      case (state)
        IDLE, CRASHED: begin
          if (start) begin
            state       <= RUN;
            spawn_valid <= 1'b0;
            spawn_slot  <= 1'b0;
            step_period <= 25'(PERIOD_INIT);
            level       <= 6'd0;
            spawn_cnt   <= '0;
            speed_cnt   <= '0;
          end
        end

        RUN: begin
          if (collision) begin
            // Collision wins over the tick: freeze everything, withdraw any request.
            state       <= CRASHED;
            spawn_valid <= 1'b0;
          end else begin
            if (tick_in) begin
              spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + 1'b1;
              speed_cnt <= speed_wrap ? '0 : speed_cnt + 1'b1;
              if (speed_wrap) begin
                step_period <= period_dec(step_period);
                level       <= level_inc(level);
              end
            end

            if (xfer) begin
              spawn_valid <= 1'b0;
              spawn_slot  <= ~spawn_slot;
`ifdef LANE_NO_REPEAT_EN
              last_lane   <= cur_lane;
`endif
            end

            // A pending, unaccepted request makes this attempt a drop.
            if (spawn_wrap && (!spawn_valid || xfer)) begin
              spawn_valid <= 1'b1;
              spawn_x     <= lane_x(chosen_lane);
`ifdef LANE_NO_REPEAT_EN
              cur_lane    <= chosen_lane;
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
